psum_accumulator: RTL and testbench
===================================

// Module: psum_accumulator
// PURPOSE
//  Downstream consumer of the 16-bit carry-select adder: accumulates a stream of
//  16-bit partial products (non-zero taps of one sparse kernel window) into one
//  16-bit partial sum, and hands it to the next stage over a valid/ready handshake.
//  The running sum is computed by instantiating carrySelectAdder16bit (acc + in_data).
//  Sits between the sparse multiplier array and the activation/output buffer.
// PARAMETERS
//  MAX_TERMS  27  max terms per window; the window closes when this count is reached
//  CNT_W      5   width of the term counter; must satisfy 2**CNT_W > MAX_TERMS
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      in_data/in_last valid
//  in_ready   out  1      block can accept a term this cycle
//  in_data    in   16     partial product, two's complement
//  in_last    in   1      marks the final term of the current window
//  out_valid  out  1      out_sum/out_count/out_ovf valid
//  out_ready  in   1      downstream accepts the result
//  out_sum    out  16     window sum, modulo 2^16
//  out_count  out  CNT_W  number of terms accepted in the window
//  out_ovf    out  1      sticky signed overflow seen during the window
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0,
//   out_ovf=0, in_ready=0 during the reset cycle, then 1.
//  Accept = in_valid & in_ready. Result hand-off = out_valid & out_ready.
//  States:
//   IDLE  : in_ready=1, acc=0, count=0. On accept -> ACCUM, or -> HOLD if the
//           window closes on this term.
//   ACCUM : in_ready=1. On accept: acc<=adder(acc,in_data), count<=count+1.
//           Window closes if in_last=1 or count+1==MAX_TERMS -> HOLD.
//           No accept -> stay; acc and count hold.
//   HOLD  : in_ready=0, out_valid=1. out_sum/out_count/out_ovf are frozen.
//           On hand-off -> IDLE; acc, count and ovf are cleared in the same edge.
//  Latency: out_valid rises on the clock edge that accepts the closing term, so it is
//   visible the next cycle. out_sum includes that term.
//  Minimum window spacing: the HOLD hand-off cycle plus one IDLE cycle. No input is
//   accepted while out_valid=1.
//  Arithmetic: plain 16-bit wrap (the adder has no carry-out).
//   ovf |= (acc[15]==in_data[15]) & (sum[15]!=acc[15]), evaluated on each accept.
//  MAX_TERMS reached without in_last: the window closes anyway. The next term starts
//   a new window.
//  in_last together with count+1==MAX_TERMS: one close only; out_count=MAX_TERMS.
//  in_data==0 is accumulated and counted like any other term.
//  out_ready held high continuously: hand-off happens in the first HOLD cycle.
//  rst mid-window or in HOLD: the partial sum is discarded. The pending result is
//   dropped with no out_valid pulse. All regs return to reset values.
//  in_valid while in_ready=0: ignored; upstream must hold the data (AXI-style).
// TESTING
//  T1 terms 5,7,-3 with in_last on -3, out_ready=1 -> out_sum=9, out_count=3,
//     out_ovf=0, out_valid high exactly 1 cycle.
//  T2 27 terms of 1 with no in_last -> auto-close; out_sum=27, out_count=27.
//     A 28th term opens a new window with count=1.
//  T3 terms 0x7FFF,1 with last -> out_sum=0x8000, out_ovf=1.
//     The next window (2,last) -> out_sum=2, out_ovf=0 (ovf cleared).
//  T4 window 4,4(last) with out_ready=0 for 5 cycles -> out_valid, out_sum=8 stable,
//     in_ready=0. Inputs offered meanwhile are not consumed. Release -> IDLE.
//  T5 rst asserted after 2 accepted terms -> no out_valid.
//     Next window 10(last) -> out_sum=10, out_count=1.
//  T6 random valid/ready throttling, 1000 windows -> scoreboard (mod-2^16 sum,
//     count, ovf) matches exactly.

Source files
------------

// File: rtl/psum_accumulator.sv
// Sparse-kernel partial-sum accumulator: folds a stream of 16-bit partial products
// into one window sum using the carry-select adder, then offers it downstream.

module csa_ripple4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];
endmodule

module carrySelectAdder16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    // carry[k] is the carry into nibble k; nibble 0 ripples, upper nibbles pick a
    // precomputed result once their carry-in is known.
    logic [3:0] carry;

    csa_ripple4 u_nib0 (
        .a    (a[3:0]),
        .b    (b[3:0]),
        .cin  (1'b0),
        .sum  (sum[3:0]),
        .cout (carry[1])
    );

    assign carry[0] = 1'b0;

    for (genvar k = 1; k < 4; k++) begin : g_nib
        logic [3:0] sum_c0;
        logic [3:0] sum_c1;

        if (k < 3) begin : g_mid
            logic cout_c0;
            logic cout_c1;

            csa_ripple4 u_c0 (
                .a    (a[4*k +: 4]),
                .b    (b[4*k +: 4]),
                .cin  (1'b0),
                .sum  (sum_c0),
                .cout (cout_c0)
            );

            csa_ripple4 u_c1 (
                .a    (a[4*k +: 4]),
                .b    (b[4*k +: 4]),
                .cin  (1'b1),
                .sum  (sum_c1),
                .cout (cout_c1)
            );

            assign carry[k+1] = carry[k] ? cout_c1 : cout_c0;
        end else begin : g_top
            // Top nibble wraps: no carry-out leaves the adder.
            assign sum_c0 = a[4*k +: 4] + b[4*k +: 4];
            assign sum_c1 = a[4*k +: 4] + b[4*k +: 4] + 4'd1;
        end

        assign sum[4*k +: 4] = carry[k] ? sum_c1 : sum_c0;
    end
endmodule

module psum_accumulator #(
    parameter int MAX_TERMS = 27,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);
    // Handshake: a term transfers on a cycle where in_valid & in_ready; a result
    // transfers where out_valid & out_ready. Producers keep data stable until then.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_t           state;
    state_t           state_next;
    logic [15:0]      acc;
    logic [15:0]      acc_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_inc;
    logic             ovf;
    logic             ovf_next;
    logic             ovf_term;
    logic [15:0]      sum;
    logic             accept;
    logic             handoff;
    logic             closing;
    logic             load_out;

    // acc is held at zero in IDLE, so the first term of a window uses the same path.
    carrySelectAdder16bit u_adder (
        .a   (acc),
        .b   (in_data),
        .sum (sum)
    );

    always_comb begin
        in_ready  = ~rst & (state != HOLD);
        out_valid = (state == HOLD);
        accept    = in_valid & in_ready;
        handoff   = out_valid & out_ready;
        count_inc = count + 1'b1;
        closing   = in_last | (count_inc == MAX_CNT);
        ovf_term  = (acc[15] == in_data[15]) & (sum[15] != acc[15]);
        dbg_state = state;
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;
        load_out   = 1'b0;

        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next   = sum;
                    count_next = count_inc;
                    ovf_next   = ovf | ovf_term;
                    if (closing) begin
                        state_next = HOLD;
                        load_out   = 1'b1;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (handoff) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
                count_next = '0;
                ovf_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
            // Result registers only change when a window closes, so they stay frozen in HOLD.
            if (load_out) begin
                out_sum   <= acc_next;
                out_count <= count_next;
                out_ovf   <= ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and throttled-random checks for psum_accumulator.

module tb_psum_accumulator;
    localparam int MAX_TERMS = 27;
    localparam int CNT_W     = 5;
    localparam int W         = 16 + CNT_W + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    psum_accumulator #(
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        bad++;
        $display("FAIL watchdog sim_time=%0t limit=3000000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Offers one term from a negedge and returns 1 time unit after the accepting edge.
    task automatic send_term(input logic [15:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_sum !== 16'h0000) begin bad++; $display("FAIL rst_out_sum got=%h exp=0000", out_sum); end
        total++; if (out_count !== 5'd0) begin bad++; $display("FAIL rst_out_count got=%0d exp=0", out_count); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got=%b exp=0", out_ovf); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_term(16'd5, 1'b0);
        send_term(16'd7, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0", out_valid); end
        send_term(16'hFFFD, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", out_valid); end
        total++; if (out_sum !== 16'd9) begin bad++; $display("FAIL t1_sum got=%h exp=0009", out_sum); end
        total++; if (out_count !== 5'd3) begin bad++; $display("FAIL t1_count got=%0d exp=3", out_count); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL t1_ovf got=%b exp=0", out_ovf); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t1_in_ready_hold got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_valid_one_cycle got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t1_in_ready_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_max_terms();
        out_ready = 1'b1;
        for (int i = 1; i <= MAX_TERMS; i++) begin
            send_term(16'd1, 1'b0);
            if (i == MAX_TERMS - 1) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t2_early_close got=%b exp=0", out_valid); end
            end
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t2_valid got=%b exp=1", out_valid); end
        total++; if (out_sum !== 16'd27) begin bad++; $display("FAIL t2_sum got=%h exp=001b", out_sum); end
        total++; if (out_count !== 5'd27) begin bad++; $display("FAIL t2_count got=%0d exp=27", out_count); end
        @(posedge clk); #1;
        send_term(16'd1, 1'b0);
        total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL t2_new_window_state got=%0d exp=1", dbg_state); end
        send_term(16'd1, 1'b1);
        total++; if (out_count !== 5'd2) begin bad++; $display("FAIL t2_new_count got=%0d exp=2", out_count); end
        total++; if (out_sum !== 16'd2) begin bad++; $display("FAIL t2_new_sum got=%h exp=0002", out_sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_ovf();
        out_ready = 1'b1;
        send_term(16'h7FFF, 1'b0);
        send_term(16'h0001, 1'b1);
        total++; if (out_sum !== 16'h8000) begin bad++; $display("FAIL t3_sum got=%h exp=8000", out_sum); end
        total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL t3_ovf got=%b exp=1", out_ovf); end
        @(posedge clk); #1;
        send_term(16'h0002, 1'b1);
        total++; if (out_sum !== 16'h0002) begin bad++; $display("FAIL t3_next_sum got=%h exp=0002", out_sum); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL t3_ovf_cleared got=%b exp=0", out_ovf); end
        @(posedge clk); #1;
        send_term(16'h8000, 1'b0);
        send_term(16'hFFFF, 1'b1);
        total++; if (out_sum !== 16'h7FFF) begin bad++; $display("FAIL t3_neg_sum got=%h exp=7fff", out_sum); end
        total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL t3_neg_ovf got=%b exp=1", out_ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_terms();
        out_ready = 1'b1;
        send_term(16'hFFFF, 1'b0);
        send_term(16'h0000, 1'b0);
        send_term(16'h0006, 1'b1);
        total++; if (out_sum !== 16'h0005) begin bad++; $display("FAIL zero_sum got=%h exp=0005", out_sum); end
        total++; if (out_count !== 5'd3) begin bad++; $display("FAIL zero_count got=%0d exp=3", out_count); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b exp=0", out_ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_term(16'd4, 1'b0);
        send_term(16'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'd99; in_last = 1'b1;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t4_valid cyc=%0d got=%b exp=1", i, out_valid); end
            total++; if (out_sum !== 16'd8) begin bad++; $display("FAIL t4_sum cyc=%0d got=%h exp=0008", i, out_sum); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t4_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t4_release_valid got=%b exp=0", out_valid); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t4_release_state got=%0d exp=0", dbg_state); end
        send_term(16'd3, 1'b1);
        total++; if (out_sum !== 16'd3) begin bad++; $display("FAIL t4_after_sum got=%h exp=0003", out_sum); end
        total++; if (out_count !== 5'd1) begin bad++; $display("FAIL t4_after_count got=%0d exp=1", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        send_term(16'd100, 1'b0);
        send_term(16'd200, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t5_in_ready got=%b exp=0", in_ready); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t5_state got=%0d exp=0", dbg_state); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t5_no_valid cyc=%0d got=%b exp=0", i, out_valid); end
        end
        send_term(16'd10, 1'b1);
        total++; if (out_sum !== 16'd10) begin bad++; $display("FAIL t5_sum got=%h exp=000a", out_sum); end
        total++; if (out_count !== 5'd1) begin bad++; $display("FAIL t5_count got=%0d exp=1", out_count); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_term(16'd7, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t5_hold_drop_valid got=%b exp=0", out_valid); end
        total++; if (out_sum !== 16'd0) begin bad++; $display("FAIL t5_hold_drop_sum got=%h exp=0000", out_sum); end
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_term(16'd11, 1'b1);
        total++; if (out_sum !== 16'd11) begin bad++; $display("FAIL b2b_first got=%h exp=000b", out_sum); end
        send_term(16'd22, 1'b1);
        total++; if (out_sum !== 16'd22) begin bad++; $display("FAIL b2b_second got=%h exp=0016", out_sum); end
        total++; if (out_count !== 5'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic drv_done;
        drv_done = 1'b0;
        exp_q.delete();
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    int len;
                    logic last_on_max;
                    logic [15:0] m_acc;
                    logic [15:0] s;
                    logic [15:0] d;
                    int m_cnt;
                    logic m_ovf;
                    if (bad > 50) break;
                    len = ($urandom_range(0, 9) == 0) ? MAX_TERMS : int'($urandom_range(1, 8));
                    last_on_max = 1'($urandom_range(0, 1));
                    m_acc = '0; m_cnt = 0; m_ovf = 1'b0;
                    for (int t = 0; t < len; t++) begin
                        d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
                        repeat ($urandom_range(0, 1)) @(posedge clk);
                        send_term(d, (t == len - 1) && (len < MAX_TERMS || last_on_max));
                        s = m_acc + d;
                        if (m_acc[15] == d[15] && s[15] != m_acc[15]) m_ovf = 1'b1;
                        m_acc = s;
                        m_cnt++;
                    end
                    exp_q.push_back({m_acc, CNT_W'(m_cnt), m_ovf});
                end
                drv_done = 1'b1;
            end
            begin
                int got;
                int guard;
                logic [W-1:0] e;
                got = 0; guard = 0;
                while (got < 1000 && guard < 60000 && !(drv_done && exp_q.size() == 0)) begin
                    @(negedge clk);
                    guard++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL t6_unexpected got=%h/%0d/%b exp=none", out_sum, out_count, out_ovf);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_sum, out_count, out_ovf} !== e) begin
                                bad++;
                                $display("FAIL t6_result n=%0d got=%h/%0d/%b exp=%h/%0d/%b", got,
                                         out_sum, out_count, out_ovf, e[W-1 -: 16], e[CNT_W:1], e[0]);
                            end
                        end
                        got++;
                    end
                end
                if (guard >= 60000) begin
                    total++; bad++;
                    $display("FAIL t6_timeout got=%0d exp=1000", got);
                end
            end
        join
        @(negedge clk); out_ready = 1'b1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t6_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_terms();
        test_ovf();
        test_zero_terms();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
